// File: rtl/inert_spi_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : inert_pkg
// Purpose : Shared types and constants for the inertial-sensor SPI sequencer:
//           FSM state encoding, the SPI command words, and a helper that
//           maps a configuration index to its command word.
// Revision: 1.0 - initial release
// ============================================================================
package inert_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    CFG_WT   = 3'd1,
    IDLE     = 3'd2,
    RDL      = 3'd3,
    RDH      = 3'd4
  } seq_state_t;

  // Configuration writes, issued in index order after power-up
  localparam logic [15:0] CFG0  = 16'h0D02;  // INT on gyro data-ready
  localparam logic [15:0] CFG1  = 16'h1160;  // gyro ODR 416 Hz
  localparam logic [15:0] CFG2  = 16'h1440;  // rounding enable

  // Yaw-rate register reads (read bit set in the top byte)
  localparam logic [15:0] RD_YL = 16'hA600;
  localparam logic [15:0] RD_YH = 16'hA700;

  localparam int CFG_CNT = 3;

  function automatic logic [15:0] cfg_word(input logic [1:0] idx);
    logic [15:0] w;
    case (idx)
      2'd0:    w = CFG0;
      2'd1:    w = CFG1;
      default: w = CFG2;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inert_spi_seq_if.sv
`default_nettype none
// ============================================================================
// Interface: inert_spi_seq_if
// Purpose  : Bundles the sequencer's link to the SPI monarch (wrt/wt_data out,
//            done/rd_data in) with its result outputs to the heading
//            integrator (yaw_rt/vld) and the init_done status flag.
// Modports : master - the sequencer side
//            slave  - the monarch / consumer side (used by a bench model)
// Revision : 1.0 - initial release
// ============================================================================
interface inert_spi_seq_if;

  logic        wrt;        // one-cycle transaction start pulse
  logic [15:0] wt_data;    // SPI command word
  logic        done;       // transaction complete, level until next wrt
  logic [15:0] rd_data;    // SPI response, low byte is register value
  logic [15:0] yaw_rt;     // signed yaw rate {yawH, yawL}
  logic        vld;        // one-cycle pulse when yaw_rt updates
  logic        init_done;  // sticky configuration-complete flag

  modport master (
    output wrt, wt_data, yaw_rt, vld, init_done,
    input  done, rd_data
  );

  modport slave (
    input  wrt, wt_data, yaw_rt, vld, init_done,
    output done, rd_data
  );

endinterface
`default_nettype wire

// File: rtl/inert_spi_seq_int_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : int_sync_edge
// Purpose : Three-flop synchroniser for an asynchronous active-high input
//           with a rising-edge detector between the second and third flop.
//           The rise pulse is combinational from the flop outputs and lasts
//           one clk, seen by a downstream register 3 clk after the input rise.
// Ports   : clk      - system clock
//           rst_n    - asynchronous active-low reset (chain clears to 0)
//           async_in - asynchronous input
//           rise     - one-cycle pulse on a synchronised rising edge
// Revision: 1.0 - initial release
// ============================================================================
module int_sync_edge (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic async_in,
  output logic      rise
);

  logic [2:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 3'b000;
    end else begin
      r_sync <= {r_sync[1:0], async_in};
    end
  end

  // Flops 1 and 0 are the metastability-settling stages; the edge is taken
  // between the second and third flop.
  assign rise = r_sync[1] & ~r_sync[2];

endmodule
`default_nettype wire

// File: rtl/inert_spi_seq.sv
`default_nettype none
// ============================================================================
// Module  : inert_spi_seq
// Purpose : Command sequencer upstream of the 16-bit SPI monarch. Waits for
//           sensor power-up, issues three configuration writes, then on each
//           data-ready interrupt reads yaw low/high bytes and presents the
//           assembled 16-bit yaw-rate sample with a one-cycle vld pulse.
// Ports   : clk   - system clock
//           rst_n - asynchronous active-low reset
//           INT   - sensor data-ready, asynchronous, active-high
//           bus   - inert_spi_seq_if.master (wrt, wt_data, done, rd_data,
//                   yaw_rt, vld, init_done)
// Params  : PWR_WAIT_W - power-up wait is 2^PWR_WAIT_W clk cycles
// Revision: 1.0 - initial release
// ============================================================================
import inert_pkg::*;

module inert_spi_seq #(
  parameter int PWR_WAIT_W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         INT,
  inert_spi_seq_if.master   bus
);

  logic                  w_int_rise;
  seq_state_t            r_state;
  logic [PWR_WAIT_W-1:0] r_wait_cnt;
  logic [1:0]            r_cfg_idx;
  logic                  r_guard;    // first cycle after an issue: ignore done
  logic                  r_pending;  // INT edge seen while a read was in flight
  logic [7:0]            r_yaw_l;    // low byte held until the high byte lands

  // Upper response byte carries no register data.
  logic w_unused;
  assign w_unused = ^bus.rd_data[15:8];

  int_sync_edge u_int_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (INT),
    .rise     (w_int_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= PWR_WAIT;
      r_wait_cnt    <= '0;
      r_cfg_idx     <= 2'd0;
      r_guard       <= 1'b0;
      r_pending     <= 1'b0;
      r_yaw_l       <= 8'h00;
      bus.wrt       <= 1'b0;
      bus.wt_data   <= 16'h0000;
      bus.yaw_rt    <= 16'h0000;
      bus.vld       <= 1'b0;
      bus.init_done <= 1'b0;
    end else begin
      bus.wrt <= 1'b0;
      bus.vld <= 1'b0;

      case (r_state)
        PWR_WAIT: begin
          // Counter stops at all-ones and is held from then on.
          if (&r_wait_cnt) begin
            bus.wrt     <= 1'b1;
            bus.wt_data <= CFG0;
            r_cfg_idx   <= 2'd0;
            r_guard     <= 1'b1;
            r_state     <= CFG_WT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        CFG_WT: begin
          // INT edges here are deliberately dropped: no pending is recorded.
          if (r_guard) begin
            r_guard <= 1'b0;
          end else if (bus.done) begin
            if (r_cfg_idx == 2'(CFG_CNT - 1)) begin
              bus.init_done <= 1'b1;
              r_state       <= IDLE;
            end else begin
              r_cfg_idx   <= r_cfg_idx + 2'd1;
              bus.wrt     <= 1'b1;
              bus.wt_data <= cfg_word(r_cfg_idx + 2'd1);
              r_guard     <= 1'b1;
            end
          end
        end

        IDLE: begin
          if (w_int_rise || r_pending) begin
            r_pending   <= 1'b0;
            bus.wrt     <= 1'b1;
            bus.wt_data <= RD_YL;
            r_guard     <= 1'b1;
            r_state     <= RDL;
          end
        end

        RDL: begin
          if (w_int_rise) begin
            r_pending <= 1'b1;
          end
          if (r_guard) begin
            r_guard <= 1'b0;
          end else if (bus.done) begin
            r_yaw_l     <= bus.rd_data[7:0];
            bus.wrt     <= 1'b1;
            bus.wt_data <= RD_YH;
            r_guard     <= 1'b1;
            r_state     <= RDH;
          end
        end

        RDH: begin
          // An edge on the completing cycle also lands in pending, so IDLE
          // starts the next read on the following cycle.
          if (w_int_rise) begin
            r_pending <= 1'b1;
          end
          if (r_guard) begin
            r_guard <= 1'b0;
          end else if (bus.done) begin
            bus.yaw_rt <= {bus.rd_data[7:0], r_yaw_l};
            bus.vld    <= 1'b1;
            r_state    <= IDLE;
          end
        end

        default: begin
          r_state <= PWR_WAIT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
